// File: rtl/ins_fetch_unit.sv
// rtl/ins_fetch_unit.sv - instruction RAM read initiator with credit-limited prefetch FIFO
// Optional same-cycle bypass of returning RAM data to the core: define FETCH_BYPASS_EN.
module ins_fetch_unit #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic                  stop,
    input  logic                  jump,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0]      mem_dataIn,
    output logic [WIDTH-1:0]      ins_out,
    output logic                  ins_valid,
    input  logic                  ins_ready,
    output logic                  busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int UW = CW + 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  inflight_q, inflight_d;
    logic [WIDTH-1:0]      fifo_q [FIFO_DEPTH];
    logic [WIDTH-1:0]      fifo_d [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;

    logic                  fetching;
    logic                  do_jump;
    logic                  flush;
    logic                  empty;
    logic                  byp_active;
    logic                  take;
    logic                  pop;
    logic                  push;
    logic                  credit_ok;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [UW-1:0]         used;
    logic [UW-1:0]         limit;

    assign fetching = (state_q == S_FETCH);
    assign do_jump  = jump && fetching && !stop;
    assign flush    = stop || do_jump;
    assign empty    = (count_q == '0);

`ifdef FETCH_BYPASS_EN
    // Returning word goes straight to the core when nothing older is queued.
    assign byp_active = empty && inflight_q && !flush;
`else
    assign byp_active = 1'b0;
`endif

    assign ins_valid = !empty || byp_active;
    assign take      = ins_valid && ins_ready && !flush;
    assign pop       = take && !empty;
    assign push      = inflight_q && !flush && !(byp_active && ins_ready);

    // A word consumed this cycle frees its slot in time for the read issued now.
    assign used      = UW'(count_q) + UW'(inflight_q);
    assign limit     = UW'(FIFO_DEPTH) + UW'(take);
    assign credit_ok = (used < limit);
    assign issue     = fetching && !jump && !stop && credit_ok;

    assign pc_inc   = (pc_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : pc_q + ADDR_WIDTH'(1);
    assign mem_addr = pc_q;
    assign busy     = fetching;

    always_comb begin
        ins_out = '0;
        if (byp_active) begin
            ins_out = mem_dataIn;
        end else if (!empty) begin
            ins_out = fifo_q[rd_ptr_q];
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inflight_d = issue;
        if (stop) begin
            state_d = S_IDLE;
        end else if (!fetching && start) begin
            state_d = S_FETCH;
            pc_d    = start_addr;
        end else if (do_jump) begin
            pc_d = jump_addr;
        end else if (issue) begin
            pc_d = pc_inc;
        end
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q] = mem_dataIn;
                wr_ptr_d         = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            fifo_q     <= fifo_d;
        end
    end
endmodule

// File: tb/tb_ins_fetch_unit.sv
// tb/tb_ins_fetch_unit.sv - directed self-checking bench for ins_fetch_unit
module tb_ins_fetch_unit;
    localparam int WIDTH = 8;
    localparam int DEPTH = 256;
    localparam int AW    = 8;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 3;
`endif

    logic             clk = 1'b0;
    logic             rstN;
    logic             start;
    logic [AW-1:0]    start_addr;
    logic             stop;
    logic             jump;
    logic [AW-1:0]    jump_addr;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_dataIn = '0;
    logic [WIDTH-1:0] ins_out;
    logic             ins_valid;
    logic             ins_ready;
    logic             busy;

    logic [WIDTH-1:0] ram [DEPTH];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) mem_dataIn <= ram[mem_addr];

    ins_fetch_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rstN(rstN), .start(start), .start_addr(start_addr),
        .stop(stop), .jump(jump), .jump_addr(jump_addr), .mem_addr(mem_addr),
        .mem_dataIn(mem_dataIn), .ins_out(ins_out), .ins_valid(ins_valid),
        .ins_ready(ins_ready), .busy(busy)
    );

    always @(negedge clk) begin
        if (rstN) begin
            checks++;
            if (dut.count_q > 2) begin
                errors++;
                $display("FAIL overflow: count=%0d limit=2", dut.count_q);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [AW-1:0] a);
        start = 1'b1;
        start_addr = a;
        step();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        ins_ready = 1'b0;
        step();
        stop = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        rstN = 1'b0; start = 1'b0; start_addr = '0; stop = 1'b0;
        jump = 1'b0; jump_addr = '0; ins_ready = 1'b0;
        step();
        step();
        checks++;
        if (mem_addr !== 8'd0 || ins_out !== 8'd0 || ins_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: addr=%0d out=%0d valid=%b busy=%b expected 0 0 0 0",
                     mem_addr, ins_out, ins_valid, busy);
        end
        rstN = 1'b1;
        step();
    endtask

    task automatic test_sequential();
        ins_ready = 1'b1;
        pulse_start(8'd8);
        checks++;
        if (busy !== 1'b1 || mem_addr !== 8'd8) begin
            errors++;
            $display("FAIL seq_issue: busy=%b addr=%0d expected 1 8", busy, mem_addr);
        end
        for (int k = 1; k < LAT; k++) begin
            checks++;
            if (ins_valid !== 1'b0) begin
                errors++;
                $display("FAIL seq_latency: valid=%b at T+%0d expected 0", ins_valid, k);
            end
            step();
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (ins_valid !== 1'b1 || ins_out !== WIDTH'(8 + k)) begin
                errors++;
                $display("FAIL seq_stream: valid=%b out=%0d expected 1 %0d", ins_valid, ins_out, 8 + k);
            end
            step();
        end
        start = 1'b1;
        start_addr = 8'd200;
        checks++;
        if (ins_out !== 8'd14) begin
            errors++;
            $display("FAIL start_in_fetch_a: out=%0d expected 14", ins_out);
        end
        step();
        start = 1'b0;
        checks++;
        if (ins_valid !== 1'b1 || ins_out !== 8'd15 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_in_fetch_b: valid=%b out=%0d busy=%b expected 1 15 1",
                     ins_valid, ins_out, busy);
        end
        do_stop();
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] exp;
        ins_ready = 1'b1;
        pulse_start(8'd254);
        repeat (LAT - 1) step();
        for (int k = 0; k < 4; k++) begin
            exp = WIDTH'(254 + k);
            checks++;
            if (ins_valid !== 1'b1 || ins_out !== exp) begin
                errors++;
                $display("FAIL wrap: valid=%b out=%0d expected 1 %0d", ins_valid, ins_out, exp);
            end
            step();
        end
        do_stop();
    endtask

    task automatic test_backpressure();
        ins_ready = 1'b0;
        pulse_start(8'd8);
        repeat (LAT - 1) step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ins_valid !== 1'b1 || ins_out !== 8'd8) begin
                errors++;
                $display("FAIL bp_hold: valid=%b out=%0d expected 1 8", ins_valid, ins_out);
            end
            step();
        end
        checks++;
        if (mem_addr !== 8'd10 || ins_out !== 8'd8) begin
            errors++;
            $display("FAIL bp_addr: addr=%0d out=%0d expected 10 8", mem_addr, ins_out);
        end
        ins_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ins_valid !== 1'b1 || ins_out !== WIDTH'(8 + k)) begin
                errors++;
                $display("FAIL bp_release: valid=%b out=%0d expected 1 %0d", ins_valid, ins_out, 8 + k);
            end
            step();
        end
        do_stop();
    endtask

    task automatic test_jump();
        ins_ready = 1'b0;
        pulse_start(8'd8);
        step();
        step();
        checks++;
        if (ins_valid !== 1'b1 || ins_out !== 8'd8) begin
            errors++;
            $display("FAIL jump_pre: valid=%b out=%0d expected 1 8", ins_valid, ins_out);
        end
        jump = 1'b1;
        jump_addr = 8'd100;
        ins_ready = 1'b1;
        step();
        jump = 1'b0;
        checks++;
        if (mem_addr !== 8'd100) begin
            errors++;
            $display("FAIL jump_addr: addr=%0d expected 100", mem_addr);
        end
        for (int k = 1; k < LAT; k++) begin
            checks++;
            if (ins_valid !== 1'b0) begin
                errors++;
                $display("FAIL jump_flush: valid=%b out=%0d at J+%0d expected valid 0", ins_valid, ins_out, k);
            end
            step();
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ins_valid !== 1'b1 || ins_out !== WIDTH'(100 + k)) begin
                errors++;
                $display("FAIL jump_stream: valid=%b out=%0d expected 1 %0d", ins_valid, ins_out, 100 + k);
            end
            step();
        end
        do_stop();
    endtask

    task automatic test_stop_jump();
        ins_ready = 1'b1;
        pulse_start(8'd20);
        repeat (LAT) step();
        checks++;
        if (ins_out !== 8'd21 || mem_addr !== AW'(20 + LAT)) begin
            errors++;
            $display("FAIL sj_pre: out=%0d addr=%0d expected 21 %0d", ins_out, mem_addr, 20 + LAT);
        end
        stop = 1'b1;
        jump = 1'b1;
        jump_addr = 8'd77;
        step();
        stop = 1'b0;
        jump = 1'b0;
        checks++;
        if (busy !== 1'b0 || ins_valid !== 1'b0 || mem_addr !== AW'(20 + LAT)) begin
            errors++;
            $display("FAIL sj_stop_wins: busy=%b valid=%b addr=%0d expected 0 0 %0d",
                     busy, ins_valid, mem_addr, 20 + LAT);
        end
        step();
        checks++;
        if (ins_valid !== 1'b0) begin
            errors++;
            $display("FAIL sj_discard: valid=%b expected 0", ins_valid);
        end
        jump = 1'b1;
        jump_addr = 8'd50;
        step();
        jump = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || ins_valid !== 1'b0 || mem_addr !== AW'(20 + LAT)) begin
            errors++;
            $display("FAIL jump_in_idle: busy=%b valid=%b addr=%0d expected 0 0 %0d",
                     busy, ins_valid, mem_addr, 20 + LAT);
        end
    endtask

    task automatic test_reset_mid();
        ins_ready = 1'b1;
        pulse_start(8'd40);
        repeat (LAT + 1) step();
        checks++;
        if (ins_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: valid=%b busy=%b expected 1 1", ins_valid, busy);
        end
        rstN = 1'b0;
        #1;
        checks++;
        if (ins_valid !== 1'b0 || mem_addr !== 8'd0 || busy !== 1'b0 || ins_out !== 8'd0) begin
            errors++;
            $display("FAIL rst_async: valid=%b addr=%0d busy=%b out=%0d expected 0 0 0 0",
                     ins_valid, mem_addr, busy, ins_out);
        end
        step();
        rstN = 1'b1;
        step();
        pulse_start(8'd0);
        repeat (LAT - 1) step();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ins_valid !== 1'b1 || ins_out !== WIDTH'(k)) begin
                errors++;
                $display("FAIL rst_restart: valid=%b out=%0d expected 1 %0d", ins_valid, ins_out, k);
            end
            step();
        end
        do_stop();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = WIDTH'(i);
        test_reset();
        test_sequential();
        test_wrap();
        test_backpressure();
        test_jump();
        test_stop_jump();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
